sobel_window_stage: RTL and testbench

- Streaming edge-gradient stage between the Gaussian blur and non-maximum suppression in the Canny pipeline.
- Accepts one 8-bit raster-order pixel per write strobe and builds a 3x3 neighbourhood with two line buffers.
- Applies the Sobel operator and emits gradient magnitude plus a 2-bit quantised direction for every interior pixel: (WIDTH-2)*(HEIGHT-2) results per frame, raster order.

---
 rtl/sobel_window_stage_if.sv | 25 ++
 rtl/sobel_window_stage.sv | 132 +++++++++++++
 tb/tb_sobel_window_stage.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sobel_window_stage_if.sv
// Pixel-in / gradient-out bundle for the Sobel window stage.
// The master side produces pixels and consumes results; the slave side is the stage itself.
interface sobel_window_stage_if;
    logic        write;
    logic [7:0]  pixel_in;
    logic        ready;
    logic [10:0] sobel_mag;
    logic [1:0]  sobel_angle;

    modport master (
        output write,
        output pixel_in,
        input  ready,
        input  sobel_mag,
        input  sobel_angle
    );

    modport slave (
        input  write,
        input  pixel_in,
        output ready,
        output sobel_mag,
        output sobel_angle
    );
endinterface

// File: rtl/sobel_window_stage.sv
// Streaming 3x3 Sobel stage: two line buffers feed a shifting window, and the
// gradient magnitude and quantised direction are derived combinationally from it.
module sobel_window_stage #(
    parameter int WIDTH  = 508,
    parameter int HEIGHT = 508
) (
    input  logic          clk,
    input  logic          rst,
    sobel_window_stage_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          ready_q, ready_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (bus.write) begin
            if (col_q == CW'(WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Only windows fully inside the current frame (no row-boundary straddle) flag a result.
    assign ready_d = bus.write && (row_q >= RW'(2)) && (col_q >= CW'(2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            ready_q <= ready_d;
        end
    end

    // Line buffers: lb1 holds row r-1, lb2 row r-2. Reads are registered at the
    // column about to be accepted, so each buffer needs a single read port.
    // Contents are left unreset: no window completes until two full rows of the
    // current frame have overwritten every location.
    logic [7:0] lb1_mem [WIDTH];
    logic [7:0] lb2_mem [WIDTH];
    logic [7:0] lb1_rd_q;
    logic [7:0] lb2_rd_q;

    always_ff @(posedge clk) begin
        if (bus.write) begin
            lb1_mem[col_q] <= bus.pixel_in;
            lb2_mem[col_q] <= lb1_rd_q;
        end
        lb1_rd_q <= lb1_mem[col_d];
        lb2_rd_q <= lb2_mem[col_d];
    end

    logic [7:0] col_in [3];
    assign col_in[0] = lb2_rd_q;
    assign col_in[1] = lb1_rd_q;
    assign col_in[2] = bus.pixel_in;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            logic [7:0] tap_q [3];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tap_q[0] <= '0;
                    tap_q[1] <= '0;
                    tap_q[2] <= '0;
                end else if (bus.write) begin
                    tap_q[0] <= tap_q[1];
                    tap_q[1] <= tap_q[2];
                    tap_q[2] <= col_in[gi];
                end
            end
        end
    endgenerate

    logic [7:0] p0, p1, p2, p3, p5, p6, p7, p8;
    assign p0 = g_row[0].tap_q[0];
    assign p1 = g_row[0].tap_q[1];
    assign p2 = g_row[0].tap_q[2];
    assign p3 = g_row[1].tap_q[0];
    assign p5 = g_row[1].tap_q[2];
    assign p6 = g_row[2].tap_q[0];
    assign p7 = g_row[2].tap_q[1];
    assign p8 = g_row[2].tap_q[2];

    logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg;
    logic [10:0] gx, gy, ax, ay;
    logic [13:0] ax2, ay2, ax5, ay5;
    logic [1:0]  angle;

    assign gx_pos = {3'b0, p2} + {2'b0, p5, 1'b0} + {3'b0, p8};
    assign gx_neg = {3'b0, p0} + {2'b0, p3, 1'b0} + {3'b0, p6};
    assign gy_pos = {3'b0, p6} + {2'b0, p7, 1'b0} + {3'b0, p8};
    assign gy_neg = {3'b0, p0} + {2'b0, p1, 1'b0} + {3'b0, p2};

    // Each side is at most 1020, so the 11-bit wrapped difference is exact two's complement.
    assign gx = gx_pos - gx_neg;
    assign gy = gy_pos - gy_neg;
    assign ax = gx[10] ? 11'(-gx) : gx;
    assign ay = gy[10] ? 11'(-gy) : gy;

    assign ax2 = {2'b0, ax, 1'b0};
    assign ay2 = {2'b0, ay, 1'b0};
    assign ax5 = 14'(ax) * 14'd5;
    assign ay5 = 14'(ay) * 14'd5;

    always_comb begin
        angle = 2'd3;
        if (ay5 <= ax2) begin
            angle = 2'd0;
        end else if (ax5 <= ay2) begin
            angle = 2'd2;
        end else if (gx[10] == gy[10]) begin
            angle = 2'd1;
        end
    end

    assign bus.ready       = ready_q;
    assign bus.sobel_mag   = ax + ay;
    assign bus.sobel_angle = angle;
endmodule

// File: tb/tb_sobel_window_stage.sv
// Directed frames on a 5x5 image with hand-computed Sobel results.
module tb_sobel_window_stage;
    localparam int W = 5;
    localparam int H = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sobel_window_stage_if bus ();

    sobel_window_stage #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    int   accepts    = 0;
    logic prev_write = 1'b0;
    int   res_cnt    = 0;
    int   gap_err    = 0;
    int   res_mag [256];
    int   res_ang [256];
    int   res_acc [256];

    always @(posedge clk) begin
        prev_write <= bus.write;
        if (bus.write && !rst) accepts <= accepts + 1;
    end

    always @(negedge clk) begin
        if (!rst && bus.ready) begin
            if (res_cnt < 256) begin
                res_mag[res_cnt] = int'(bus.sobel_mag);
                res_ang[res_cnt] = int'(bus.sobel_angle);
                res_acc[res_cnt] = accepts;
            end
            res_cnt = res_cnt + 1;
            if (!prev_write) gap_err = gap_err + 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Modes: 0 const100, 1 h-ramp, 2 v-ramp, 3 diagonal, 4 anti-diagonal, 5 step, 6 const50
    function automatic logic [7:0] pix(input int mode, input int r, input int c);
        case (mode)
            0:       return 8'd100;
            1:       return 8'(10 * c);
            2:       return 8'(10 * r);
            3:       return 8'(10 * (r + c));
            4:       return 8'(100 + 10 * c - 10 * r);
            5:       return (c >= 2) ? 8'd255 : 8'd0;
            default: return 8'd50;
        endcase
    endfunction

    function automatic int exp_mag(input int mode, input int cc);
        case (mode)
            1, 2:    return 80;
            3, 4:    return 160;
            5:       return (cc == 3) ? 0 : 1020;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_ang(input int mode);
        case (mode)
            2:       return 2;
            3:       return 1;
            4:       return 3;
            default: return 0;
        endcase
    endfunction

    task automatic drive(input logic w, input logic [7:0] p);
        @(negedge clk);
        bus.write    = w;
        bus.pixel_in = p;
    endtask

    task automatic run_frame(input int mode, input bit gaps, input string name);
        int rbase;
        int abase;
        int idx;
        rbase = res_cnt;
        abase = accepts;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps && ($urandom_range(0, 1) == 1)) drive(1'b0, 8'd0);
                drive(1'b1, pix(mode, r, c));
            end
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 8'd0);
        check({name, "_count"}, res_cnt - rbase, (W - 2) * (H - 2));
        if (res_cnt > rbase) check({name, "_first_at"}, res_acc[rbase] - abase, 2 * W + 3);
        for (int k = 0; k < (W - 2) * (H - 2); k++) begin
            idx = rbase + k;
            if (idx < res_cnt) begin
                $display("[TB] %s result %0d: mag=%0d angle=%0d", name, k, res_mag[idx], res_ang[idx]);
                check({name, "_mag"}, res_mag[idx], exp_mag(mode, (k % 3) + 1));
                check({name, "_ang"}, res_ang[idx], exp_ang(mode));
            end
        end
    endtask

    initial begin
        bus.write    = 1'b0;
        bus.pixel_in = 8'd0;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", int'(bus.ready), 0);
        check("rst_mag", int'(bus.sobel_mag), 0);
        check("rst_angle", int'(bus.sobel_angle), 0);
        rst = 1'b0;

        run_frame(0, 1'b0, "const100");
        run_frame(1, 1'b0, "hramp");
        run_frame(2, 1'b0, "vramp");
        run_frame(3, 1'b0, "diag");
        run_frame(4, 1'b0, "antidiag");
        run_frame(5, 1'b0, "step");
        run_frame(1, 1'b1, "hramp_gaps");

        // Abandon a diagonal frame in row 3 just after a nonzero result appears.
        for (int i = 0; i < 3 * W + 3; i++) drive(1'b1, pix(3, i / W, i % W));
        @(negedge clk);
        rst          = 1'b1;
        bus.write    = 1'b0;
        bus.pixel_in = 8'd0;
        #1;
        check("midrst_ready", int'(bus.ready), 0);
        check("midrst_mag", int'(bus.sobel_mag), 0);
        check("midrst_angle", int'(bus.sobel_angle), 0);
        @(negedge clk);
        check("midrst_ready_hold", int'(bus.ready), 0);
        check("midrst_mag_hold", int'(bus.sobel_mag), 0);
        rst = 1'b0;

        run_frame(6, 1'b0, "const50");

        check("ready_after_idle", gap_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
